// File: rtl/memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_if
// Bundles every signal between the memory arbiter, its two requesters
// (instruction cache, data/vector load-store unit) and the single-port RAM.
//
//   inst_vis_signal/inst_vis_addr        instruction request (0=NOP, 1=READ)
//   inst_data/inst_done                  instruction result and one-cycle done
//   data_vis_signal/data_vis_addr        data request (0=NOP, 1=READ, 2=WRITE)
//   data_wdata                           data write value
//   data_rdata/data_done                 data result and one-cycle done
//   mem_status                           0=RESTING, 1=INST_WORKING, 2=DATA_WORKING
//   ram_en/ram_we/ram_addr/ram_wdata     RAM command
//   ram_rdata                            RAM read value
//
// Modports: slave = the arbiter, master = requesters plus RAM.
// -----------------------------------------------------------------------------
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
);
  logic [1:0]            inst_vis_signal;
  logic [ADDR_WIDTH-1:0] inst_vis_addr;
  logic [LEN-1:0]        inst_data;
  logic                  inst_done;
  logic [1:0]            data_vis_signal;
  logic [ADDR_WIDTH-1:0] data_vis_addr;
  logic [LEN-1:0]        data_wdata;
  logic [LEN-1:0]        data_rdata;
  logic                  data_done;
  logic [1:0]            mem_status;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [LEN-1:0]        ram_wdata;
  logic [LEN-1:0]        ram_rdata;

  modport slave (
    input  inst_vis_signal, inst_vis_addr, data_vis_signal, data_vis_addr,
           data_wdata, ram_rdata,
    output inst_data, inst_done, data_rdata, data_done, mem_status,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output inst_vis_signal, inst_vis_addr, data_vis_signal, data_vis_addr,
           data_wdata, ram_rdata,
    input  inst_data, inst_done, data_rdata, data_done, mem_status,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one single-port main memory between the instruction cache and the
// data/vector load-store unit. Each side owns a one-entry request slot; the
// arbiter grants the RAM to one side at a time (data first), holds the RAM
// command for a fixed MEM_LATENCY, then returns read data with a one-cycle
// done pulse. mem_status tells both requesters who currently owns the RAM.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (abandons any in-flight access)
//   bus    memory_arbiter_if.slave, all request/result/RAM signals
//
// Optional build macro MEM_ARB_FAIRNESS_EN: when both slots are pending and
// the previous completion belonged to the data side, the instruction side
// wins, so fetches cannot starve behind a stream of data accesses.
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int LEN         = 32,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  memory_arbiter_if.slave  bus
);

  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [1:0] MEM_RESTING      = 2'd0;
  localparam logic [1:0] MEM_INST_WORKING = 2'd1;
  localparam logic [1:0] MEM_DATA_WORKING = 2'd2;

  // Counter reload: completion happens MEM_LATENCY edges after the grant.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;

  // One-entry request slots
  logic                  inst_pend;
  logic [ADDR_WIDTH-1:0] inst_addr_q;
  logic                  data_pend;
  logic                  data_we_q;
  logic [ADDR_WIDTH-1:0] data_addr_q;
  logic [LEN-1:0]        data_wdata_q;

  logic inst_complete;
  logic data_complete;
  logic inst_req;
  logic data_req;
  logic inst_take;
  logic data_take;
  logic pick_data;

  assign inst_complete = (state == INST_BUSY) && (cnt == '0);
  assign data_complete = (state == DATA_BUSY) && (cnt == '0);

  // Encodings other than READ (inst) or READ/WRITE (data) are NOPs.
  assign inst_req = (bus.inst_vis_signal == MEM_READ);
  assign data_req = (bus.data_vis_signal == MEM_READ) ||
                    (bus.data_vis_signal == MEM_WRITE);

  // A slot that completes on this edge is free for a new request on the
  // same edge, so a requester holding its request gets back-to-back service.
  assign inst_take = inst_req && (!inst_pend || inst_complete);
  assign data_take = data_req && (!data_pend || data_complete);

`ifdef MEM_ARB_FAIRNESS_EN
  logic last_was_data;
  assign pick_data = data_pend && !(inst_pend && last_was_data);
`else
  assign pick_data = data_pend;
`endif

  // ---------------------------------------------------------------------------
  // Request slots
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a RAM array, so the payload is
      // reset along with the valid bits and never powers up as X.
      inst_pend    <= 1'b0;
      inst_addr_q  <= '0;
      data_pend    <= 1'b0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
    end else begin
      if (inst_take) begin
        inst_pend   <= 1'b1;
        inst_addr_q <= bus.inst_vis_addr;
      end else if (inst_complete) begin
        inst_pend   <= 1'b0;
      end

      if (data_take) begin
        data_pend    <= 1'b1;
        data_we_q    <= (bus.data_vis_signal == MEM_WRITE);
        data_addr_q  <= bus.data_vis_addr;
        data_wdata_q <= bus.data_wdata;
      end else if (data_complete) begin
        data_pend    <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant / access FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.mem_status <= MEM_RESTING;
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.inst_data  <= '0;
      bus.inst_done  <= 1'b0;
      bus.data_rdata <= '0;
      bus.data_done  <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      last_was_data  <= 1'b0;
`endif
    end else begin
      // Done outputs are pulses: low unless a completion sets them below.
      bus.inst_done <= 1'b0;
      bus.data_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (pick_data) begin
            state          <= DATA_BUSY;
            bus.mem_status <= MEM_DATA_WORKING;
            bus.ram_en     <= 1'b1;
            bus.ram_we     <= data_we_q;
            bus.ram_addr   <= data_addr_q;
            bus.ram_wdata  <= data_wdata_q;
            cnt            <= CNT_LOAD;
          end else if (inst_pend) begin
            state          <= INST_BUSY;
            bus.mem_status <= MEM_INST_WORKING;
            bus.ram_en     <= 1'b1;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= inst_addr_q;
            cnt            <= CNT_LOAD;
          end
        end

        INST_BUSY, DATA_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (state == INST_BUSY) begin
              bus.inst_data <= bus.ram_rdata;
              bus.inst_done <= 1'b1;
`ifdef MEM_ARB_FAIRNESS_EN
              last_was_data <= 1'b0;
`endif
            end else begin
              // A write leaves the previous read result visible.
              if (!bus.ram_we) begin
                bus.data_rdata <= bus.ram_rdata;
              end
              bus.data_done <= 1'b1;
`ifdef MEM_ARB_FAIRNESS_EN
              last_was_data <= 1'b1;
`endif
            end
            // Returning to IDLE forces one RESTING cycle before the next grant.
            bus.ram_en     <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.mem_status <= MEM_RESTING;
            state          <= IDLE;
          end
        end

        default: begin
          state          <= IDLE;
          bus.ram_en     <= 1'b0;
          bus.ram_we     <= 1'b0;
          bus.mem_status <= MEM_RESTING;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Bench for memory_arbiter. dut uses MEM_LATENCY=2, dut1 uses MEM_LATENCY=1.
// Each RAM is modelled as a sparse array whose read port only presents valid
// data once ram_en has been held for the configured latency. Expected results
// come from a separate reference memory updated in request order.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int AW = 17;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDR_WIDTH(AW), .LEN(DW)) bus  ();
  memory_arbiter_if #(.ADDR_WIDTH(AW), .LEN(DW)) bus1 ();

  memory_arbiter #(.ADDR_WIDTH(AW), .LEN(DW), .MEM_LATENCY(2), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  memory_arbiter #(.ADDR_WIDTH(AW), .LEN(DW), .MEM_LATENCY(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int total = 0;
  int bad   = 0;

  // {mem_status, ram_en, ram_we, inst_done, data_done}
  wire [5:0] ctl0 = {bus.mem_status, bus.ram_en, bus.ram_we, bus.inst_done, bus.data_done};
  wire [5:0] ctl1 = {bus1.mem_status, bus1.ram_en, bus1.ram_we, bus1.inst_done, bus1.data_done};

  // ---------------------------------------------------------------------------
  // Memories: ram0/ram1 are the physical RAMs, ref_mem is the reference model
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram0    [int];
  logic [DW-1:0] ram1    [int];
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] init_val(input int a);
    return (32'(a) * 32'h0001_9E37) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ram0_rd(input int a);
    return ram0.exists(a) ? ram0[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ram1_rd(input int a);
    return ram1.exists(a) ? ram1[a] : init_val(a);
  endfunction

  // RAM responders: en counts consecutive cycles of ram_en; data becomes valid
  // only once en has reached the latency, otherwise a poison word is driven.
  int en0 = 0;
  int en1 = 0;

  always begin
    @(posedge clk);
    #2;
    if (bus.ram_en) en0++; else en0 = 0;
    if (bus.ram_en && bus.ram_we && en0 == 2) ram0[int'(bus.ram_addr)] = bus.ram_wdata;
    bus.ram_rdata = (bus.ram_en && en0 >= 2) ? ram0_rd(int'(bus.ram_addr)) : 32'hBAD0_BAD0;
  end

  always begin
    @(posedge clk);
    #2;
    if (bus1.ram_en) en1++; else en1 = 0;
    if (bus1.ram_en && bus1.ram_we && en1 == 1) ram1[int'(bus1.ram_addr)] = bus1.ram_wdata;
    bus1.ram_rdata = (bus1.ram_en && en1 >= 1) ? ram1_rd(int'(bus1.ram_addr)) : 32'hBAD0_BAD0;
  end

  // Last expected data-side read result (held across writes).
  logic [DW-1:0] exp_drd = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.inst_vis_signal  = 2'd0; bus.inst_vis_addr  = '0;
    bus.data_vis_signal  = 2'd0; bus.data_vis_addr  = '0; bus.data_wdata  = '0;
    bus1.inst_vis_signal = 2'd0; bus1.inst_vis_addr = '0;
    bus1.data_vis_signal = 2'd0; bus1.data_vis_addr = '0; bus1.data_wdata = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    total++; if (ctl0 !== 6'd0) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl0, 6'd0); end
    total++; if (bus.inst_data !== '0) begin bad++; $display("FAIL reset_inst_data: got %h want 0", bus.inst_data); end
    total++; if (bus.data_rdata !== '0) begin bad++; $display("FAIL reset_data_rdata: got %h want 0", bus.data_rdata); end
    total++; if ({bus.ram_addr, bus.ram_wdata} !== '0) begin bad++; $display("FAIL reset_ram_bus: got %h/%h want 0", bus.ram_addr, bus.ram_wdata); end
    total++; if (ctl1 !== 6'd0) begin bad++; $display("FAIL reset_ctl_lat1: got %b want %b", ctl1, 6'd0); end
    rst_n = 1'b1;
    step();
    exp_drd = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_inst_read();
    ram0[16] = 32'h0050_0013;
    bus.inst_vis_signal = 2'd1; bus.inst_vis_addr = 17'h00010;
    step();                                   // edge 0: request captured
    bus.inst_vis_signal = 2'd0;
    total++; if (ctl0 !== 6'b00_0000) begin bad++; $display("FAIL inst_e0: got %b want %b", ctl0, 6'b00_0000); end
    step();                                   // edge 1: grant
    total++; if (ctl0 !== 6'b01_1000) begin bad++; $display("FAIL inst_e1: got %b want %b", ctl0, 6'b01_1000); end
    total++; if (bus.ram_addr !== 17'h00010) begin bad++; $display("FAIL inst_e1_addr: got %h want 00010", bus.ram_addr); end
    step();
    total++; if (ctl0 !== 6'b01_1000) begin bad++; $display("FAIL inst_e2: got %b want %b", ctl0, 6'b01_1000); end
    step();                                   // edge 3: completion
    total++; if (ctl0 !== 6'b00_0010) begin bad++; $display("FAIL inst_e3: got %b want %b", ctl0, 6'b00_0010); end
    total++; if (bus.inst_data !== 32'h0050_0013) begin bad++; $display("FAIL inst_e3_data: got %h want 00500013", bus.inst_data); end
    step();
    total++; if (ctl0 !== 6'b00_0000) begin bad++; $display("FAIL inst_e4: got %b want %b", ctl0, 6'b00_0000); end
    total++; if (bus.inst_data !== 32'h0050_0013) begin bad++; $display("FAIL inst_e4_hold: got %h want 00500013", bus.inst_data); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    logic [DW-1:0] iexp;
    iexp = ref_rd(32'h20);
    bus.inst_vis_signal = 2'd1; bus.inst_vis_addr = 17'h00020;
    bus.data_vis_signal = 2'd2; bus.data_vis_addr = 17'h1F000; bus.data_wdata = 32'hDEAD_BEEF;
    ref_mem[32'h1F000] = 32'hDEAD_BEEF;
    step();                                   // edge 0
    drive_idle();
    step();                                   // edge 1: data granted
    total++; if (ctl0 !== 6'b10_1100) begin bad++; $display("FAIL prio_data_grant: got %b want %b", ctl0, 6'b10_1100); end
    total++; if ({bus.ram_addr, bus.ram_wdata} !== {17'h1F000, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL prio_data_cmd: got %h/%h want 1f000/deadbeef", bus.ram_addr, bus.ram_wdata); end
    repeat (2) step();                        // edge 3: data completion
    total++; if (ctl0 !== 6'b00_0001) begin bad++; $display("FAIL prio_data_done: got %b want %b", ctl0, 6'b00_0001); end
    total++; if (bus.data_rdata !== exp_drd) begin bad++; $display("FAIL prio_write_rdata_held: got %h want %h", bus.data_rdata, exp_drd); end
    step();                                   // edge 4: inst granted
    total++; if (ctl0 !== 6'b01_1000) begin bad++; $display("FAIL prio_inst_grant: got %b want %b", ctl0, 6'b01_1000); end
    total++; if (bus.ram_addr !== 17'h00020) begin bad++; $display("FAIL prio_inst_addr: got %h want 00020", bus.ram_addr); end
    repeat (2) step();                        // edge 6: inst completion
    total++; if (ctl0 !== 6'b00_0010) begin bad++; $display("FAIL prio_inst_done: got %b want %b", ctl0, 6'b00_0010); end
    total++; if (bus.inst_data !== iexp) begin bad++; $display("FAIL prio_inst_data: got %h want %h", bus.inst_data, iexp); end
    total++; if (ram0_rd(32'h1F000) !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL prio_ram_written: got %h want deadbeef", ram0_rd(32'h1F000)); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation();
    int first_inst = -1;
    int ddone = 0;
    int idone_win = 0;
    int idone = 0;
    int exp_first;
    int exp_ddone;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_first = 4; exp_ddone = 2;
`else
    exp_first = -1; exp_ddone = 3;
`endif
    bus.data_vis_signal = 2'd1; bus.data_vis_addr = 17'h00100;
    bus.inst_vis_signal = 2'd1; bus.inst_vis_addr = 17'h00030;
    for (int e = 0; e < 12; e++) begin
      step();
      if (e == 0) bus.inst_vis_signal = 2'd0;
      if (bus.mem_status == 2'd1 && first_inst < 0) first_inst = e;
      if (bus.inst_done) idone_win++;
      if (bus.data_done) begin
        ddone++;
        exp_drd = ref_rd(32'h100);
        total++; if (bus.data_rdata !== exp_drd) begin bad++; $display("FAIL starve_data_rdata: got %h want %h", bus.data_rdata, exp_drd); end
      end
    end
    bus.data_vis_signal = 2'd0;
    total++; if (first_inst != exp_first) begin bad++; $display("FAIL starve_first_inst_grant: got %0d want %0d", first_inst, exp_first); end
    total++; if (ddone != exp_ddone) begin bad++; $display("FAIL starve_data_count: got %0d want %0d", ddone, exp_ddone); end
    idone = idone_win;
    for (int e = 0; e < 12; e++) begin
      step();
      if (bus.inst_done) begin
        idone++;
        total++; if (bus.inst_data !== ref_rd(32'h30)) begin bad++; $display("FAIL starve_inst_data: got %h want %h", bus.inst_data, ref_rd(32'h30)); end
      end
      if (bus.data_done) exp_drd = ref_rd(32'h100);
    end
    total++; if (idone != 1) begin bad++; $display("FAIL starve_inst_count: got %0d want 1", idone); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignored();
    int idone = 0;
    int saw_b = 0;
    bus.inst_vis_signal = 2'd1; bus.inst_vis_addr = 17'h00040;
    step();                                   // edge 0: A captured
    bus.inst_vis_signal = 2'd0;
    step();                                   // edge 1: A granted
    bus.inst_vis_signal = 2'd1; bus.inst_vis_addr = 17'h00050;
    step();                                   // edge 2: B offered while slot full
    bus.inst_vis_signal = 2'd0;
    for (int e = 0; e < 12; e++) begin
      if (bus.ram_en && bus.ram_addr == 17'h00050) saw_b++;
      if (bus.inst_done) begin
        idone++;
        total++; if (bus.inst_data !== ref_rd(32'h40)) begin bad++; $display("FAIL ignore_inst_data: got %h want %h", bus.inst_data, ref_rd(32'h40)); end
      end
      step();
    end
    total++; if (idone != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", idone); end
    total++; if (saw_b != 0) begin bad++; $display("FAIL ignore_b_served: got %0d want 0", saw_b); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int dd = 0;
    bit got = 0;
    bus.data_vis_signal = 2'd1; bus.data_vis_addr = 17'h00200;
    step();                                   // edge 0
    bus.data_vis_signal = 2'd0;
    step();                                   // edge 1: granted, counter==1
    total++; if (ctl0 !== 6'b10_1000) begin bad++; $display("FAIL rmid_grant: got %b want %b", ctl0, 6'b10_1000); end
    rst_n = 1'b0;
    #1;
    total++; if (ctl0 !== 6'd0) begin bad++; $display("FAIL rmid_ctl: got %b want 0", ctl0); end
    total++; if ({bus.inst_data, bus.data_rdata} !== '0) begin bad++; $display("FAIL rmid_results: got %h/%h want 0", bus.inst_data, bus.data_rdata); end
    total++; if (bus.ram_addr !== '0) begin bad++; $display("FAIL rmid_ram_addr: got %h want 0", bus.ram_addr); end
    for (int e = 0; e < 3; e++) begin
      step();
      if (bus.data_done) dd++;
    end
    rst_n = 1'b1;
    exp_drd = '0;
    for (int e = 0; e < 3; e++) begin
      step();
      if (bus.data_done) dd++;
    end
    total++; if (dd != 0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", dd); end
    bus.data_vis_signal = 2'd1; bus.data_vis_addr = 17'h00200;
    step();
    bus.data_vis_signal = 2'd0;
    for (int e = 0; e < 10 && !got; e++) begin
      step();
      if (bus.data_done) got = 1;
    end
    exp_drd = ref_rd(32'h200);
    total++; if (!got) begin bad++; $display("FAIL rmid_after_timeout: got no done want done"); end
    else if (bus.data_rdata !== exp_drd) begin bad++; $display("FAIL rmid_after_data: got %h want %h", bus.data_rdata, exp_drd); end
    repeat (2) step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    bit inst_out = 0, data_out = 0, data_wr = 0;
    int inst_age = 0, data_age = 0;
    logic [DW-1:0] inst_exp = '0, data_exp = '0;
    int a;
    int v;
    for (int cyc = 0; cyc < 360; cyc++) begin
      step();
      if (bus.inst_done) begin
        total++;
        if (!inst_out || bus.inst_data !== inst_exp) begin
          bad++; $display("FAIL rand_inst: got %h (pending %0d) want %h", bus.inst_data, inst_out, inst_exp); end
        inst_out = 0;
      end
      if (bus.data_done) begin
        if (!data_wr) exp_drd = data_exp;
        total++;
        if (!data_out || bus.data_rdata !== exp_drd) begin
          bad++; $display("FAIL rand_data: got %h (pending %0d wr %0d) want %h", bus.data_rdata, data_out, data_wr, exp_drd); end
        data_out = 0;
      end
      if (inst_out && ++inst_age > 30) begin
        total++; bad++; $display("FAIL rand_inst_timeout: got no done want done"); inst_out = 0;
      end
      if (data_out && ++data_age > 30) begin
        total++; bad++; $display("FAIL rand_data_timeout: got no done want done"); data_out = 0;
      end
      // Instruction requester: reads only from a region data never writes.
      if (cyc < 300 && !inst_out && $urandom_range(0, 2) == 0) begin
        a = 32'h08000 + int'($urandom_range(0, 255));
        bus.inst_vis_signal = 2'd1; bus.inst_vis_addr = AW'(a);
        inst_exp = ref_rd(a); inst_out = 1; inst_age = 0;
      end else begin
        v = int'($urandom_range(0, 2));
        bus.inst_vis_signal = (v == 1) ? 2'd3 : 2'(v);
        bus.inst_vis_addr   = AW'($urandom);
      end
      // Data requester: reads and writes on a small window to force reuse.
      if (cyc < 300 && !data_out && $urandom_range(0, 1) == 0) begin
        a = 32'h00300 + int'($urandom_range(0, 15));
        data_wr = 1'($urandom_range(0, 1));
        bus.data_vis_addr = AW'(a);
        bus.data_wdata    = $urandom;
        if (data_wr) begin
          bus.data_vis_signal = 2'd2;
          ref_mem[a] = bus.data_wdata;
        end else begin
          bus.data_vis_signal = 2'd1;
        end
        data_exp = ref_rd(a); data_out = 1; data_age = 0;
      end else begin
        bus.data_vis_signal = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
        bus.data_vis_addr   = AW'($urandom);
        bus.data_wdata      = $urandom;
      end
    end
    drive_idle();
    total++; if (inst_out || data_out) begin bad++; $display("FAIL rand_drain: got pending %0d/%0d want 0/0", inst_out, data_out); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_latency1();
    bus1.data_vis_signal = 2'd2; bus1.data_vis_addr = 17'h00004; bus1.data_wdata = 32'hCAFE_F00D;
    step();                                   // capture
    bus1.data_vis_signal = 2'd0;
    step();                                   // grant
    total++; if (ctl1 !== 6'b10_1100) begin bad++; $display("FAIL lat1_wr_grant: got %b want %b", ctl1, 6'b10_1100); end
    step();                                   // grant + 1: completion
    total++; if (ctl1 !== 6'b00_0001) begin bad++; $display("FAIL lat1_wr_done: got %b want %b", ctl1, 6'b00_0001); end
    bus1.data_vis_signal = 2'd1; bus1.data_vis_addr = 17'h00004;
    step();                                   // capture read
    bus1.data_vis_signal = 2'd0;
    step();                                   // grant
    total++; if (ctl1 !== 6'b10_1000) begin bad++; $display("FAIL lat1_rd_grant: got %b want %b", ctl1, 6'b10_1000); end
    step();                                   // completion
    total++; if (ctl1 !== 6'b00_0001) begin bad++; $display("FAIL lat1_rd_done: got %b want %b", ctl1, 6'b00_0001); end
    total++; if (bus1.data_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL lat1_rd_data: got %h want cafef00d", bus1.data_rdata); end
    step();
    total++; if (ctl1 !== 6'b00_0000) begin bad++; $display("FAIL lat1_rest: got %b want 0", ctl1); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    drive_idle();
    bus.ram_rdata  = 32'hBAD0_BAD0;
    bus1.ram_rdata = 32'hBAD0_BAD0;
    test_reset();
    test_inst_read();
    test_priority();
    repeat (3) step();
    test_starvation();
    repeat (4) step();
    test_ignored();
    test_reset_mid();
    test_random();
    repeat (4) step();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
